// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential signed radix-2 Booth multiplier with start/busy/done handshake
// Optional BOOTH_EARLY_TERM_EN: finish early once all remaining Booth pairs are 00/11.
module booth_mul_seq #(
  parameter int BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIT_LEN-1:0]     in1,
  input  logic [BIT_LEN-1:0]     in2,
  output logic                   busy,
  output logic                   done,
  output logic [2*BIT_LEN-1:0]   out
);

  localparam int CW = $clog2(BIT_LEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [BIT_LEN-1:0] a;
  logic [BIT_LEN-1:0] b;
  logic [BIT_LEN:0]   x;
  logic               q;
  logic [CW-1:0]      cnt;

  logic [BIT_LEN:0]   a_ext;
  logic [BIT_LEN:0]   x_sum;
  logic [BIT_LEN:0]   x_nxt;
  logic [BIT_LEN-1:0] b_nxt;
  logic [CW-1:0]      cnt_nxt;

  // One extra accumulator bit keeps -2^(n-1) * -2^(n-1) exact.
  assign a_ext = {a[BIT_LEN-1], a};

  always_comb begin
    case ({b[0], q})
      2'b10:   x_sum = x - a_ext;
      2'b01:   x_sum = x + a_ext;
      default: x_sum = x;
    endcase
  end

  assign x_nxt   = {x_sum[BIT_LEN], x_sum[BIT_LEN:1]};
  assign b_nxt   = {x_sum[0], b[BIT_LEN-1:1]};
  assign cnt_nxt = cnt - CW'(1);

`ifdef BOOTH_EARLY_TERM_EN
  logic                        rem_uniform;
  logic signed [2*BIT_LEN:0]   xb_sh;

  // Remaining pairs are all 00/11 when the unconsumed B bits all equal q.
  always_comb begin
    rem_uniform = 1'b1;
    for (int i = 0; i < BIT_LEN; i++) begin
      if (CW'(i) < cnt && b[i] != q) rem_uniform = 1'b0;
    end
  end

  assign xb_sh = $signed({x, b}) >>> cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      a     <= '0;
      b     <= '0;
      x     <= '0;
      q     <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= in1;
            b     <= in2;
            x     <= '0;
            q     <= 1'b0;
            cnt   <= CW'(BIT_LEN);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
`ifdef BOOTH_EARLY_TERM_EN
          if (rem_uniform) begin
            x     <= xb_sh[2*BIT_LEN:BIT_LEN];
            b     <= xb_sh[BIT_LEN-1:0];
            cnt   <= '0;
            out   <= xb_sh[2*BIT_LEN-1:0];
            done  <= 1'b1;
            state <= DONE;
          end else
`endif
          begin
            x   <= x_nxt;
            b   <= b_nxt;
            q   <= b[0];
            cnt <= cnt_nxt;
            if (cnt_nxt == '0) begin
              out   <= {x_nxt[BIT_LEN-1:0], b_nxt};
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard bench for booth_mul_seq at BIT_LEN 4 and 8
// Honours BOOTH_EARLY_TERM_EN for expected latencies.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    longint exp;
    int     acc;
    int     lat;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  longint last4 = 0;
  longint last8 = 0;

  logic       rst4, start4, busy4, done4;
  logic [3:0] in1_4, in2_4;
  logic [7:0] out4;

  logic        rst8, start8, busy8, done8;
  logic [7:0]  in1_8, in2_8;
  logic [15:0] out8;

  booth_mul_seq #(.BIT_LEN(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .in1(in1_4), .in2(in2_4),
    .busy(busy4), .done(done4), .out(out4)
  );

  booth_mul_seq #(.BIT_LEN(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .in1(in1_8), .in2(in2_8),
    .busy(busy8), .done(done8), .out(out8)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: done pulse with no outstanding operation at cycle %0d", name, cyc);
  endtask

  function automatic longint ref_mul(input int bl, input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return p & ((longint'(1) << (2 * bl)) - 1);
  endfunction

  // Edges from acceptance to the edge that raises done.
  function automatic int lat_model(input int bl, input logic [7:0] b);
    int   et = 0;
    logic prev;
    bit   ok;
`ifdef BOOTH_EARLY_TERM_EN
    et = 1;
`endif
    if (et != 0) begin
      for (int s = 0; s < bl; s++) begin
        prev = (s == 0) ? 1'b0 : b[s-1];
        ok = 1'b1;
        for (int j = s; j < bl; j++) if (b[j] != prev) ok = 1'b0;
        if (ok) return s + 1;
      end
    end
    return bl;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst4) begin
      if (done4) begin
        if (q4.size() == 0) unexpected("dut4_unexpected_done");
        else begin
          e = q4.pop_front();
          chk("dut4_out", longint'(out4), e.exp);
          chk("dut4_latency", longint'(cyc - e.acc), longint'(e.lat));
          chk("dut4_busy_in_done", longint'(busy4), 1);
          last4 = e.exp;
        end
      end else if (!busy4) chk("dut4_out_hold", longint'(out4), last4);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst8) begin
      if (done8) begin
        if (q8.size() == 0) unexpected("dut8_unexpected_done");
        else begin
          e = q8.pop_front();
          chk("dut8_out", longint'(out8), e.exp);
          chk("dut8_latency", longint'(cyc - e.acc), longint'(e.lat));
          last8 = e.exp;
        end
      end else if (!busy8) chk("dut8_out_hold", longint'(out8), last8);
    end
  end

  task automatic wait_idle4;
    int g = 0;
    while (busy4 && g < 50) begin
      tick();
      g++;
    end
    chk("dut4_idle_timeout", longint'(busy4), 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input longint exp, input int lat);
    wait_idle4();
    in1_4  = a;
    in2_4  = b;
    start4 = 1'b1;
    q4.push_back('{exp: exp, acc: cyc + 1, lat: lat});
    tick();
    start4 = 1'b0;
    in1_4  = 4'($urandom);
    in2_4  = 4'($urandom);
    chk("dut4_busy_rise", longint'(busy4), 1);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    longint     exp;
    int         lat_et;
  } dir_t;

  task automatic run4;
    dir_t       dir[5];
    logic [7:0] v;
    int         lat;
    rst4 = 1'b1; start4 = 1'b0; in1_4 = '0; in2_4 = '0;
    repeat (3) tick();
    chk("dut4_reset_busy", longint'(busy4), 0);
    chk("dut4_reset_done", longint'(done4), 0);
    chk("dut4_reset_out", longint'(out4), 0);
    rst4 = 1'b0;

    dir[0] = '{4'd3,   4'd5,   64'h0F, 4};
    dir[1] = '{4'hD,   4'd7,   64'hEB, 4};
    dir[2] = '{4'h8,   4'h8,   64'h40, 4};
    dir[3] = '{4'd7,   4'hF,   64'hF9, 2};
    dir[4] = '{4'd5,   4'd0,   64'h00, 1};
    foreach (dir[i]) begin
      lat = 4;
`ifdef BOOTH_EARLY_TERM_EN
      lat = dir[i].lat_et;
`endif
      op4(dir[i].a, dir[i].b, dir[i].exp, lat);
    end

    // Abort during the second CALC cycle.
    wait_idle4();
    in1_4 = 4'd3; in2_4 = 4'd5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    chk("dut4_abort_busy", longint'(busy4), 0);
    chk("dut4_abort_done", longint'(done4), 0);
    chk("dut4_abort_out", longint'(out4), 0);
    last4 = 0;
    rst4 = 1'b0;
    repeat (7) tick();

    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      op4(v[7:4], v[3:0],
          ref_mul(4, int'($signed(v[7:4])), int'($signed(v[3:0]))),
          lat_model(4, {4'b0, v[3:0]}));
    end

    // Start held/toggled with operands changing every cycle.
    for (int c = 0; c < 300; c++) begin
      start4 = ($urandom_range(0, 3) != 0);
      in1_4  = 4'($urandom);
      in2_4  = 4'($urandom);
      if (start4 && !busy4)
        q4.push_back('{exp: ref_mul(4, int'($signed(in1_4)), int'($signed(in2_4))),
                       acc: cyc + 1, lat: lat_model(4, {4'b0, in2_4})});
      tick();
    end
    start4 = 1'b0;
  endtask

  task automatic run8;
    int n = 0;
    int g = 0;
    rst8 = 1'b1; start8 = 1'b0; in1_8 = '0; in2_8 = '0;
    repeat (3) tick();
    chk("dut8_reset_busy", longint'(busy8), 0);
    chk("dut8_reset_out", longint'(out8), 0);
    rst8 = 1'b0;
    while (n < 1000 && g < 15000) begin
      start8 = 1'b1;
      in1_8  = 8'($urandom);
      in2_8  = 8'($urandom);
      if (!busy8) begin
        q8.push_back('{exp: ref_mul(8, int'($signed(in1_8)), int'($signed(in2_8))),
                       acc: cyc + 1, lat: lat_model(8, in2_8)});
        n++;
      end
      tick();
      g++;
    end
    start8 = 1'b0;
    chk("dut8_accepted", longint'(n), 1000);
  endtask

  initial begin
    int g = 0;
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
    in1_4 = '0; in2_4 = '0; in1_8 = '0; in2_8 = '0;
    fork
      run4();
      run8();
    join
    while ((q4.size() != 0 || q8.size() != 0) && g < 100) begin
      tick();
      g++;
    end
    tick();
    chk("dut4_drain", longint'(q4.size()), 0);
    chk("dut8_drain", longint'(q8.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
